// File: rtl/stopwatch_pkg.sv
// Shared constants and helpers for the stopwatch_ms BCD stopwatch.
package stopwatch_pkg;

  localparam int BCD_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Saturate a non-decimal nibble to 9 so the cascade only ever sees legal digits.
  function automatic logic [3:0] bcdClamp(input logic [3:0] digit);
    logic [3:0] res;
    if (digit > BCD_MAX) res = BCD_MAX;
    else                 res = digit;
    return res;
  endfunction

  function automatic int prescWidth(input int div);
    return $clog2(div);
  endfunction

endpackage

// File: rtl/stopwatch_ms_tick_gen.sv
// tick_gen: enabled modulo-DIV prescaler with synchronous zero; tick is a registered wrap pulse.
module tick_gen
  import stopwatch_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clkIn,
  input  logic resetN,
  input  logic en,
  input  logic zero,
  output logic tick
);

  localparam int CW = prescWidth(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;
  logic          tick_r;

  // Prescaler count and wrap pulse; holds while disabled so the sub-tick phase survives a pause.
  always_ff @(posedge clkIn or negedge resetN) begin
    if (!resetN) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (zero) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (en) begin
      if (cnt_r == LAST) begin
        cnt_r  <= '0;
        tick_r <= 1'b1;
      end else begin
        cnt_r  <= cnt_r + CW'(1);
        tick_r <= 1'b0;
      end
    end else begin
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/stopwatch_ms.sv
// stopwatch_ms: prescaled NUM_DIGITS-wide BCD stopwatch with start/stop/clear, load and up/down.
// Define STOPWATCH_LAP_EN to add the lap input and the lapOut capture register.
module stopwatch_ms
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int TICK_HZ    = 1000,
  parameter int NUM_DIGITS = 6
) (
  input  logic                        clkIn,
  input  logic                        resetN,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        clear,
  input  logic                        countDown,
  input  logic                        loadEn,
  input  logic [BCD_W*NUM_DIGITS-1:0] loadVal,
  output logic [BCD_W*NUM_DIGITS-1:0] timeOut,
  output logic                        running,
  output logic                        tick,
  output logic                        done
`ifdef STOPWATCH_LAP_EN
  ,
  input  logic                        lap,
  output logic [BCD_W*NUM_DIGITS-1:0] lapOut
`endif
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int W   = BCD_W * NUM_DIGITS;

  if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : gBadDiv
    $error("stopwatch_ms: CLK_HZ/TICK_HZ must be an integer >= 2");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : gBadDigits
    $error("stopwatch_ms: NUM_DIGITS must be in 1..8");
  end

  logic [W-1:0] timeOut_r, timeNext_s, incVal_s, decVal_s, loadClamp_s;
  logic         running_r, runNext_s, done_r, doneNext_s;
  logic         incWrap_s, isZero_s, tick_s;

  tick_gen #(.DIV(DIV)) uTickGen (
    .clkIn  (clkIn),
    .resetN (resetN),
    .en     (running_r),
    .zero   (clear | loadEn),
    .tick   (tick_s)
  );

  // Full-width BCD increment/decrement ripple plus the clamped load value.
  always_comb begin
    logic       carry;
    logic       borrow;
    logic [3:0] d;
    incVal_s    = '0;
    decVal_s    = '0;
    loadClamp_s = '0;
    carry       = 1'b1;
    borrow      = 1'b1;
    d           = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = timeOut_r[i*BCD_W +: BCD_W];
      if (carry) begin
        if (d == BCD_MAX) begin
          incVal_s[i*BCD_W +: BCD_W] = 4'd0;
        end else begin
          incVal_s[i*BCD_W +: BCD_W] = d + 4'd1;
          carry = 1'b0;
        end
      end else begin
        incVal_s[i*BCD_W +: BCD_W] = d;
      end
      if (borrow) begin
        if (d == 4'd0) begin
          decVal_s[i*BCD_W +: BCD_W] = BCD_MAX;
        end else begin
          decVal_s[i*BCD_W +: BCD_W] = d - 4'd1;
          borrow = 1'b0;
        end
      end else begin
        decVal_s[i*BCD_W +: BCD_W] = d;
      end
      loadClamp_s[i*BCD_W +: BCD_W] = bcdClamp(loadVal[i*BCD_W +: BCD_W]);
    end
    incWrap_s = carry;
    isZero_s  = (timeOut_r == '0);
  end

  // Control priority clear > loadEn > stop > start; a tick is applied only when neither clear nor load is active.
  always_comb begin
    timeNext_s = timeOut_r;
    runNext_s  = running_r;
    doneNext_s = 1'b0;
    if (clear) begin
      timeNext_s = '0;
    end else if (loadEn) begin
      timeNext_s = loadClamp_s;
    end else begin
      if (stop) begin
        runNext_s = 1'b0;
      end else if (start && !(countDown && isZero_s)) begin
        runNext_s = 1'b1;
      end else begin
        runNext_s = running_r;
      end
      if (tick_s) begin
        if (!countDown) begin
          timeNext_s = incVal_s;
          doneNext_s = incWrap_s;
        end else if (isZero_s) begin
          runNext_s = 1'b0;
        end else begin
          timeNext_s = decVal_s;
          if (decVal_s == '0) begin
            doneNext_s = 1'b1;
            runNext_s  = 1'b0;
          end else begin
            doneNext_s = 1'b0;
          end
        end
      end else begin
        timeNext_s = timeOut_r;
      end
    end
  end

  // Count, run flag and terminal pulse registers.
  always_ff @(posedge clkIn or negedge resetN) begin
    if (!resetN) begin
      timeOut_r <= '0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      timeOut_r <= timeNext_s;
      running_r <= runNext_s;
      done_r    <= doneNext_s;
    end
  end

  assign timeOut = timeOut_r;
  assign running = running_r;
  assign tick    = tick_s;
  assign done    = done_r;

`ifdef STOPWATCH_LAP_EN
  logic [W-1:0] lapOut_r;

  // Lap capture takes the pre-update count so a coincident tick is not reflected.
  always_ff @(posedge clkIn or negedge resetN) begin
    if (!resetN) begin
      lapOut_r <= '0;
    end else if (clear) begin
      lapOut_r <= '0;
    end else if (lap) begin
      lapOut_r <= timeOut_r;
    end else begin
      lapOut_r <= lapOut_r;
    end
  end

  assign lapOut = lapOut_r;
`endif

endmodule
